ef_tcc_mc: RTL and testbench

Multi-channel timer/counter/capture core, the parametrised successor of the 32-bit single-channel TCC. One W-bit timebase with prescaler, internal or external clock source, up/down/centre-aligned counting and one-shot mode feeds N independent channels, each configurable as edge capture (with overrun detection) or compare/PWM. The core sits behind the APB register wrapper: configuration arrives as flat inputs and events leave as single-cycle pulses that the wrapper latches into RIS.

---
 rtl/ef_tcc_mc.sv | 187 ++++++++++++++++++
 tb/tb_ef_tcc_mc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ef_tcc_mc.sv
// ef_tcc_mc: multi-channel timer/counter/capture core.
// One prescaled W-bit timebase shared by N channels, each capture or compare/PWM.
module ef_tcc_mc #(
  parameter int unsigned W  = 32,
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 8
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic           one_shot,
  input  logic           clk_src,
  input  logic           ext_clk,
  input  logic [PW-1:0]  prescale,
  input  logic [W-1:0]   period,
  input  logic [N-1:0]   ch_in,
  input  logic [2*N-1:0] ch_mode,
  input  logic [2*N-1:0] ch_edge,
  input  logic [N*W-1:0] ch_cmp,
  input  logic [N-1:0]   cap_rd,
  output logic [W-1:0]   count,
  output logic [N*W-1:0] cap_val,
  output logic [N-1:0]   pwm,
  output logic           to_pulse,
  output logic [N-1:0]   match_pulse,
  output logic [N-1:0]   cap_pulse,
  output logic [N-1:0]   ovr_pulse
);

  localparam logic [1:0]    ModeDown   = 2'b01;
  localparam logic [1:0]    ModeUpDown = 2'b10;
  localparam logic [W-1:0]  One        = W'(1);
  localparam logic [PW-1:0] PscOne     = PW'(1);

  logic [2:0]          ext_q;
  logic                en_q, run_q, run_d, dir_q, dir_d, to_q, to_d;
  logic [PW-1:0]       psc_q, psc_d;
  logic [W-1:0]        count_q, count_d;
  logic                src_ev, tick, active, upd;
  logic [N-1:0]        chs1_q, chs2_q, chs3_q, pend_q, pend_d;
  logic [N-1:0]        pwm_q, pwm_d, match_q, match_d, cap_q, ovr_q, ovr_d;
  logic [N-1:0]        is_cap, is_cmp, rise, fall, cap_ev;
  logic [N-1:0][W-1:0] cmp_v, cap_val_q, cap_val_d;

  // ext_q[1] is the synchronised level, ext_q[2] the edge register
  assign src_ev = clk_src ? (ext_q[1] & ~ext_q[2]) : 1'b1;
  assign tick   = en & src_ev & (psc_q >= prescale);
  // The cycle en is first seen high already counts as running
  assign active = run_q | ~en_q;
  assign upd    = en & active & tick;

  always_comb begin
    psc_d = psc_q;
    if (!en) begin
      psc_d = '0;
    end else if (src_ev) begin
      psc_d = (psc_q >= prescale) ? '0 : psc_q + PscOne;
    end
  end

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    run_d   = run_q;
    to_d    = 1'b0;
    if (!en) begin
      count_d = (mode == ModeDown) ? period : '0;
      dir_d   = 1'b0;
      run_d   = 1'b0;
    end else begin
      if (!en_q) run_d = 1'b1;
      if (upd) begin
        case (mode)
          ModeDown: begin
            if (count_q == '0) begin
              to_d = 1'b1;
              if (one_shot) run_d = 1'b0;
              else count_d = period;
            end else begin
              count_d = count_q - One;
            end
          end
          ModeUpDown: begin
            if (period == '0) begin
              count_d = '0;
              dir_d   = 1'b0;
              to_d    = 1'b1;
              if (one_shot) run_d = 1'b0;
            end else if (!dir_q) begin
              if (count_q >= period) begin
                dir_d   = 1'b1;
                count_d = count_q - One;
              end else begin
                count_d = count_q + One;
              end
            end else if (count_q == '0) begin
              to_d  = 1'b1;
              dir_d = 1'b0;
              if (one_shot) run_d = 1'b0;
              else count_d = count_q + One;
            end else begin
              count_d = count_q - One;
            end
          end
          default: begin
            if (count_q >= period) begin
              to_d = 1'b1;
              if (one_shot) begin
                count_d = period;
                run_d   = 1'b0;
              end else begin
                count_d = '0;
              end
            end else begin
              count_d = count_q + One;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      cmp_v[i]     = ch_cmp[i*W +: W];
      is_cap[i]    = (ch_mode[2*i +: 2] == 2'b01);
      is_cmp[i]    = (ch_mode[2*i +: 2] == 2'b10);
      rise[i]      = chs2_q[i] & ~chs3_q[i];
      fall[i]      = ~chs2_q[i] & chs3_q[i];
      cap_ev[i]    = en & is_cap[i] & ((ch_edge[2*i] & rise[i]) | (ch_edge[2*i+1] & fall[i]));
      pwm_d[i]     = is_cmp[i] & (count_q < cmp_v[i]);
      match_d[i]   = is_cmp[i] & upd & (count_d == cmp_v[i]);
      // A read landing with a new edge keeps pending set and suppresses overrun
      ovr_d[i]     = cap_ev[i] & pend_q[i] & ~cap_rd[i];
      pend_d[i]    = cap_ev[i] | (pend_q[i] & ~cap_rd[i]);
      cap_val_d[i] = cap_ev[i] ? count_q : cap_val_q[i];
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      ext_q     <= '0;
      en_q      <= 1'b0;
      run_q     <= 1'b0;
      dir_q     <= 1'b0;
      to_q      <= 1'b0;
      psc_q     <= '0;
      count_q   <= '0;
      chs1_q    <= '0;
      chs2_q    <= '0;
      chs3_q    <= '0;
      pend_q    <= '0;
      pwm_q     <= '0;
      match_q   <= '0;
      cap_q     <= '0;
      ovr_q     <= '0;
      cap_val_q <= '0;
    end else begin
      ext_q     <= {ext_q[1:0], ext_clk};
      en_q      <= en;
      run_q     <= run_d;
      dir_q     <= dir_d;
      to_q      <= to_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      chs1_q    <= ch_in;
      chs2_q    <= chs1_q;
      chs3_q    <= chs2_q;
      pend_q    <= pend_d;
      pwm_q     <= pwm_d;
      match_q   <= match_d;
      cap_q     <= cap_ev;
      ovr_q     <= ovr_d;
      cap_val_q <= cap_val_d;
    end
  end

  assign count       = count_q;
  assign cap_val     = cap_val_q;
  assign pwm         = pwm_q;
  assign to_pulse    = to_q;
  assign match_pulse = match_q;
  assign cap_pulse   = cap_q;
  assign ovr_pulse   = ovr_q;

endmodule

// File: tb/tb_ef_tcc_mc.sv
// Directed self-checking bench for ef_tcc_mc: a W=32/N=4 instance plus a W=8 instance
// used for the full-range wrap.
module tb_ef_tcc_mc;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic         en = 1'b0, one_shot = 1'b0, clk_src = 1'b0, ext_clk = 1'b0;
  logic [1:0]   mode = '0;
  logic [7:0]   prescale = '0;
  logic [31:0]  period = '0;
  logic [3:0]   ch_in = '0, cap_rd = '0;
  logic [7:0]   ch_mode = '0, ch_edge = '0;
  logic [127:0] ch_cmp = '0;
  logic [31:0]  count;
  logic [127:0] cap_val;
  logic [3:0]   pwm, match_pulse, cap_pulse, ovr_pulse;
  logic         to_pulse;

  logic         en8 = 1'b0, ch_in8 = 1'b0, cap_rd8 = 1'b0;
  logic [3:0]   prescale8 = '0;
  logic [7:0]   period8 = 8'd255, ch_cmp8 = 8'd128, count8, cap_val8;
  logic [1:0]   ch_mode8 = 2'b10, ch_edge8 = 2'b00;
  logic         pwm8, to8, match8, cap8, ovr8;

  int errors = 0;
  int checks = 0;
  int first_ev, n_ev, last_ev;

  always #5 PCLK = ~PCLK;

  ef_tcc_mc #(.W(32), .N(4), .PW(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .mode(mode), .one_shot(one_shot),
    .clk_src(clk_src), .ext_clk(ext_clk), .prescale(prescale), .period(period),
    .ch_in(ch_in), .ch_mode(ch_mode), .ch_edge(ch_edge), .ch_cmp(ch_cmp), .cap_rd(cap_rd),
    .count(count), .cap_val(cap_val), .pwm(pwm), .to_pulse(to_pulse),
    .match_pulse(match_pulse), .cap_pulse(cap_pulse), .ovr_pulse(ovr_pulse)
  );

  ef_tcc_mc #(.W(8), .N(1), .PW(4)) dut8 (
    .PCLK(PCLK), .PRESETn(PRESETn), .en(en8), .mode(mode), .one_shot(one_shot),
    .clk_src(clk_src), .ext_clk(ext_clk), .prescale(prescale8), .period(period8),
    .ch_in(ch_in8), .ch_mode(ch_mode8), .ch_edge(ch_edge8), .ch_cmp(ch_cmp8), .cap_rd(cap_rd8),
    .count(count8), .cap_val(cap_val8), .pwm(pwm8), .to_pulse(to8),
    .match_pulse(match8), .cap_pulse(cap8), .ovr_pulse(ovr8)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  // Expected up-down count for period 10, k ticks after start
  function automatic int tri_val(input int k);
    int p;
    p = k % 20;
    return (p <= 10) ? p : 20 - p;
  endfunction

  initial begin
    step(3);
    check("rst_count", count, 0);
    check("rst_cap_val", cap_val, 0);
    check("rst_pwm", pwm, 0);
    check("rst_pulses", {to_pulse, match_pulse, cap_pulse, ovr_pulse}, 0);
    check("rst_count8", count8, 0);
    PRESETn = 1'b1;
    step(1);

    // Up, one-shot, period 20
    mode = 2'b00; period = 20; one_shot = 1'b1; prescale = 0; en = 1'b1;
    first_ev = 0; n_ev = 0;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      if (to_pulse) begin
        n_ev++;
        if (first_ev == 0) first_ev = k;
      end
      if (k == 10) check("os_mid_count", count, 10);
    end
    check("os_first_to", first_ev, 21);
    check("os_to_count", n_ev, 1);
    check("os_hold", count, 20);
    en = 1'b0;
    step(1);
    check("en_off_up_load", count, 0);

    // Down, periodic, period 20
    mode = 2'b01; one_shot = 1'b0;
    step(1);
    check("en_off_down_load", count, 20);
    en = 1'b1;
    first_ev = 0; n_ev = 0; last_ev = 0;
    for (int k = 1; k <= 63; k++) begin
      step(1);
      if (k == 1) check("dn_first_dec", count, 19);
      if (to_pulse) begin
        n_ev++;
        last_ev = k;
        if (first_ev == 0) first_ev = k;
        check("dn_reload", count, 20);
      end
    end
    check("dn_first_to", first_ev, 21);
    check("dn_last_to", last_ev, 63);
    check("dn_to_count", n_ev, 3);

    // Up-down, period 10, ch0 compare at 4
    en = 1'b0; mode = 2'b10; ch_mode = 8'b0000_0010; ch_cmp[31:0] = 32'd4; period = 10;
    step(1);
    check("ud_load", count, 0);
    en = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      step(1);
      check("ud_count", count, tri_val(k));
      check("ud_pwm0", pwm[0], tri_val(k - 1) < 4);
      check("ud_match0", match_pulse[0], tri_val(k) == 4);
      check("ud_to", to_pulse, (k > 1) && (k % 20 == 1));
    end

    // Capture on ch1 rising, edges 17 cycles apart
    en = 1'b0; mode = 2'b00; period = 1000; ch_mode = 8'b0000_0100; ch_edge = 8'b0000_0100;
    step(1);
    en = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step(1);
      check("cap_pulse1", cap_pulse[1], (k == 8) || (k == 25) || (k == 42) || (k == 59) ||
            (k == 76));
      check("ovr_pulse1", ovr_pulse[1], (k == 25) || (k == 76));
      if (cap_pulse[1]) check("cap_val1", cap_val[63:32], k - 1);
      if (k == 40) check("cap_off_ch0", {cap_pulse[0], cap_val[31:0]}, 0);
      ch_in[1] = ((k >= 5) && (k < 13)) || ((k >= 22) && (k < 30)) ||
                 ((k >= 39) && (k < 47)) || ((k >= 56) && (k < 64)) || (k >= 73);
      cap_rd[1] = (k == 30) || (k == 58);
    end
    ch_in = '0;

    // External clock, prescale 1, ch2 compare at 5
    en = 1'b0; clk_src = 1'b1; prescale = 1; period = 100; ch_mode = 8'b0010_0000;
    ch_edge = '0; ch_cmp[95:64] = 32'd5;
    step(1);
    en = 1'b1;
    first_ev = 0; n_ev = 0;
    for (int c = 0; c <= 44; c++) begin
      ext_clk = (c < 40) && ((c % 4) < 2);
      step(1);
      if (match_pulse[2]) begin
        n_ev++;
        if (first_ev == 0) first_ev = c + 1;
      end
      if (c + 1 == 38) check("ext_count9", count, 4);
    end
    check("ext_match_cycle", first_ev, 39);
    check("ext_match_count", n_ev, 1);
    check("ext_final_count", count, 5);
    check("ext_pwm2", pwm[2], 0);

    // Reset while counting with pwm high
    en = 1'b0; clk_src = 1'b0; prescale = 0; period = 50; ch_mode = 8'b0000_0010;
    ch_cmp[31:0] = 32'd30;
    step(1);
    en = 1'b1;
    step(10);
    check("pre_rst_count", count, 10);
    check("pre_rst_pwm0", pwm[0], 1);
    check("pre_rst_cap_val1", cap_val[63:32], 75);
    PRESETn = 1'b0;
    step(1);
    check("mid_rst_count", count, 0);
    check("mid_rst_pwm", pwm, 0);
    check("mid_rst_cap_val", cap_val, 0);
    check("mid_rst_pulses", {to_pulse, match_pulse, cap_pulse, ovr_pulse}, 0);
    PRESETn = 1'b1;

    // ch0 cmp=0 -> pwm low; ch1 cmp=period+1 -> pwm high
    en = 1'b0; ch_mode = 8'b0000_1010; ch_cmp[31:0] = 32'd0; ch_cmp[63:32] = 32'd51;
    step(1);
    en = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step(1);
      check("pwm_const", pwm[1:0], 2'b10);
      if (k == 51) check("wrap50", {count, to_pulse, match_pulse[1:0]}, {32'd0, 1'b1, 2'b01});
    end
    en = 1'b0;

    // W=8, period 255: full-range wrap
    en8 = 1'b1;
    n_ev = 0;
    for (int k = 1; k <= 256; k++) begin
      step(1);
      if (to8) n_ev++;
      if (k == 255) check("w8_top", count8, 255);
      if (k == 256) check("w8_wrap", {count8, to8}, {8'd0, 1'b1});
    end
    check("w8_to_count", n_ev, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
